// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Hazard detection and mul/div sequencing for the 5-stage pipeline.
//   Detects load-use hazards in EX and operand hazards of branches that
//   resolve in ID. On a hazard it holds PC and IF/ID and bubbles ID/EX.
//   Drives the start/done handshake with the multi-cycle mul/div unit.
//   The handshake has a timeout that forces a release and sets a sticky
//   error. Flushes IF/ID on a taken branch.
//
// Ports
//   Clk, Rst                    clock, synchronous active-high reset
//   If_Id_Rs/Rt/UsesRt          source operands of the ID instruction
//   If_Id_Branch/MulDiv         ID instruction class
//   Take_Branch                 ID branch compare result
//   Id_Ex_Rd/RegWrite/MemRead   EX instruction destination and controls
//   Ex_Mem_Rd/MemRead           MEM instruction destination, load flag
//   Md_Done                     completion pulse from the mul/div unit
//   PC_Write, If_Id_Write       load enables; low while stalled
//   Id_Ex_Bubble                zero the ID/EX control fields
//   If_Id_Flush                 clear IF/ID on the next edge
//   Md_Start                    one-cycle start pulse to the mul/div unit
//   Md_Busy                     waiting on the mul/div unit
//   Md_Error                    sticky; set by a mul/div timeout
//   Stall_Count                 saturating count of stalled cycles
module hazard_control_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       If_Id_Rs,
  input  logic [4:0]       If_Id_Rt,
  input  logic             If_Id_UsesRt,
  input  logic             If_Id_Branch,
  input  logic             If_Id_MulDiv,
  input  logic             Take_Branch,
  input  logic [4:0]       Id_Ex_Rd,
  input  logic             Id_Ex_RegWrite,
  input  logic             Id_Ex_MemRead,
  input  logic [4:0]       Ex_Mem_Rd,
  input  logic             Ex_Mem_MemRead,
  input  logic             Md_Done,
  output logic             PC_Write,
  output logic             If_Id_Write,
  output logic             Id_Ex_Bubble,
  output logic             If_Id_Flush,
  output logic             Md_Start,
  output logic             Md_Busy,
  output logic             Md_Error,
  output logic [CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {RUN, MD_WAIT, MD_RELEASE} state_t;

  // The timer only has to reach MD_TIMEOUT-1.
  localparam int TMR_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             lu_hz;
  logic             br_hz;
  logic             hz;

  // r0 is hardwired to zero, so it never creates a dependency.
  // Rt counts only when the ID instruction actually reads it.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A branch compares in ID, so it must wait for any producer still in EX.
  // It must also wait for a load result that is still in MEM.
  // Load-use is the only case that forwarding cannot cover for non-branches.
  always_comb begin
    lu_hz = Id_Ex_MemRead && reg_match(Id_Ex_Rd, If_Id_Rs, If_Id_Rt, If_Id_UsesRt);
    br_hz = If_Id_Branch &&
            ((Id_Ex_RegWrite && reg_match(Id_Ex_Rd, If_Id_Rs, If_Id_Rt, If_Id_UsesRt)) ||
             (Ex_Mem_MemRead && reg_match(Ex_Mem_Rd, If_Id_Rs, If_Id_Rt, If_Id_UsesRt)));
    hz    = lu_hz || br_hz;
  end

  // Pipeline controls take effect at the same edge.
  // During reset they are forced to the free-running values.
  always_comb begin
    PC_Write     = 1'b1;
    If_Id_Write  = 1'b1;
    Id_Ex_Bubble = 1'b0;
    If_Id_Flush  = 1'b0;
    Md_Start     = 1'b0;
    if (!Rst) begin
      case (state)
        RUN: begin
          if (hz) begin
            PC_Write     = 1'b0;
            If_Id_Write  = 1'b0;
            Id_Ex_Bubble = 1'b1;
          end else if (If_Id_MulDiv) begin
            PC_Write     = 1'b0;
            If_Id_Write  = 1'b0;
            Id_Ex_Bubble = 1'b1;
            Md_Start     = 1'b1;
          end else begin
            If_Id_Flush  = Take_Branch && If_Id_Branch;
          end
        end
        MD_WAIT: begin
          PC_Write     = 1'b0;
          If_Id_Write  = 1'b0;
          Id_Ex_Bubble = 1'b1;
        end
        // The release cycle lets the mul/div op enter EX.
        // Hazards are not checked here because the op is already resolved.
        default: ;
      endcase
    end
  end

  assign Md_Busy = (state == MD_WAIT);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= RUN;
      timer       <= '0;
      Stall_Count <= '0;
      Md_Error    <= 1'b0;
    end else begin
      if (!PC_Write) Stall_Count <= sat_inc(Stall_Count);
      case (state)
        RUN: begin
          if (Md_Start) begin
            state <= MD_WAIT;
            timer <= '0;
          end
        end
        MD_WAIT: begin
          timer <= timer + 1'b1;
          // Completion takes priority over a timeout that occurs in the same cycle.
          if (Md_Done) begin
            state <= MD_RELEASE;
          end else if (timer == TMR_LAST) begin
            Md_Error <= 1'b1;
            state    <= MD_RELEASE;
          end
        end
        MD_RELEASE: state <= RUN;
        default:    state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and multi-cycle-unit sequencer for the 5-stage datapath, sitting alongside the forwarding unit. It detects hazards the forwarding network cannot cover: load-use in EX, and operands of branches resolved in ID. On those hazards it stalls PC and IF/ID and injects ID/EX bubbles. It also runs the start/done handshake with the multi-cycle multiply/divide unit, including a timeout, and flushes IF/ID on taken branches.

## Interface
Parameters:
- MD_TIMEOUT, 64: max MD_WAIT cycles before forced release.
- CNT_W, 16: width of the stall cycle counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- If_Id_Rs, If_Id_Rt  in  5 each  source registers of the instruction in ID.
- If_Id_UsesRt  in  1  ID instruction reads Rt.
- If_Id_Branch  in  1  ID instruction is a branch; it compares in ID.
- If_Id_MulDiv  in  1  ID instruction is a multi-cycle mul/div.
- Take_Branch  in  1  ID branch comparison result.
- Id_Ex_Rd  in  5  post-RegDst destination of the EX instruction.
- Id_Ex_RegWrite, Id_Ex_MemRead  in  1 each  EX instruction controls.
- Ex_Mem_Rd  in  5  destination of the MEM instruction.
- Ex_Mem_MemRead  in  1  MEM instruction is a load.
- Md_Done  in  1  one-cycle pulse from the mul/div unit.
- PC_Write  out  1  PC load enable.
- If_Id_Write  out  1  IF/ID load enable.
- Id_Ex_Bubble  out  1  zero ID/EX control fields this cycle.
- If_Id_Flush  out  1  clear IF/ID on the next edge.
- Md_Start  out  1  one-cycle start pulse to the mul/div unit.
- Md_Busy  out  1  high in MD_WAIT.
- Md_Error  out  1  sticky; set on timeout.
- Stall_Count  out  CNT_W  saturating count of cycles with PC_Write=0.

## Operation
- Register matching: register 0 never matches. A match on Rs always counts. A match on Rt counts only if If_Id_UsesRt=1.
- LU (load-use): Id_Ex_MemRead and Id_Ex_Rd matches a source register.
- BR (branch hazard): If_Id_Branch, plus either of:
  - Id_Ex_RegWrite and Id_Ex_Rd matches, or
  - Ex_Mem_MemRead and Ex_Mem_Rd matches.
- HZ = LU | BR. HZ is combinational on current inputs. It re-evaluates each cycle as the pipeline drains. As a result, a branch directly after a load stalls 2 cycles, and a branch after an ALU op stalls 1.
- FSM states: RUN, MD_WAIT, MD_RELEASE. Reset state is RUN.
- RUN:
  - If HZ: stall. Stall means PC_Write=0, If_Id_Write=0, Id_Ex_Bubble=1.
  - Else if If_Id_MulDiv: Md_Start=1, stall, next state MD_WAIT. The timer is cleared.
  - Else: no stall. If_Id_Flush=Take_Branch & If_Id_Branch.
- MD_WAIT:
  - Stall every cycle; Md_Busy=1; the timer increments.
  - If Md_Done: next state MD_RELEASE.
  - Else if timer == MD_TIMEOUT-1: set Md_Error, next state MD_RELEASE.
- MD_RELEASE:
  - No stall and Md_Start=0, so the mul/div instruction advances into ID/EX.
  - HZ is ignored for this one cycle; the controlling instruction is the mul/div op.
  - Next state RUN.
- Priority: Rst > HZ > mul/div start. If_Id_Flush is never asserted while stalled.
- Stall_Count increments on each cycle with PC_Write=0 and saturates at all-ones. Md_Error clears only on Rst.

## Timing
- Stall, bubble and flush outputs are combinational from state and inputs, and take effect at the same edge.
- Md_Start is high exactly one cycle: the RUN cycle before MD_WAIT.
- Md_Done arriving in RUN or MD_RELEASE is ignored.
- Md_Done arriving in the same cycle as the timeout takes the done path; Md_Error stays 0.
- Minimum mul/div occupancy: 1 start cycle + ≥1 MD_WAIT cycle + 1 release cycle.
- Reset values: state=RUN, timer=0, Stall_Count=0, Md_Error=0, Md_Busy=0.
- While Rst=1, outputs are forced regardless of inputs: PC_Write=1, If_Id_Write=1, Id_Ex_Bubble=0, If_Id_Flush=0, Md_Start=0.
- Rst asserted in MD_WAIT: the next cycle is RUN, with no release cycle and no error.

## Test plan
- Load-use: Id_Ex_MemRead=1, Id_Ex_Rd=5, If_Id_Rs=5 for one cycle, then MemRead=0 -> exactly 1 cycle of PC_Write=0 and Id_Ex_Bubble=1; Stall_Count=1.
- Branch after load: If_Id_Branch=1, Rs=7. Drive the load through EX (cycle 1), then MEM (cycle 2) -> 2 stall cycles. Then Take_Branch=1 -> If_Id_Flush=1 for 1 cycle.
- Rd=0 / Rt-unused: Id_Ex_Rd=0 with a load; then Rd=3=If_Id_Rt with If_Id_UsesRt=0 -> no stall in either case.
- Mul/div: If_Id_MulDiv=1 and Md_Done 5 cycles after Md_Start -> Md_Start for 1 cycle, Md_Busy for 5 cycles, then 1 release cycle with PC_Write=1; total Stall_Count=6.
- Timeout with MD_TIMEOUT=4 and no Md_Done -> MD_WAIT for 4 cycles, then Md_Error=1 (sticky). A second mul/div completes normally with Md_Error still 1.
- Reset mid-MD_WAIT: Rst pulsed in MD_WAIT cycle 2 -> next cycle RUN, Md_Busy=0, Stall_Count=0, Md_Error=0.
